execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- ID/EX pipeline register plus combinational execute logic for the 5-stage RV32I pipeline.
- Captures the decode-stage control bundle, including the 3-bit ALU control from the ALU decoder, together with operands.
- Applies hazard-unit forwarding, runs the ALU and resolves branch/jump redirect.
- Outputs feed the EX/MEM register and the hazard unit.

Parameters:
word_width, 32, datapath width in bits
reg_addr_width, 5, register-index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
StallE  in  1  hold ID/EX contents
FlushE  in  1  load bubble into ID/EX
RegWriteD  in  1  decode register-write enable
ResultSrcD  in  2  decode writeback-source select
MemWriteD  in  1  decode store enable
JumpD  in  1  decode jal
BranchD  in  1  decode beq
ALUControlD  in  3  decode ALU operation
ALUSrcD  in  1  0 = register B operand, 1 = immediate B operand
RD1D, RD2D  in  word_width  register-file read data
PCD, PCPlus4D, ImmExtD  in  word_width  PC, PC+4, extended immediate
Rs1D, Rs2D, RdD  in  reg_addr_width  register indices
ForwardAE, ForwardBE  in  2  forwarding selects
ALUResultM  in  word_width  forwarded value from MEM
ResultW  in  word_width  forwarded value from WB
RegWriteE, MemWriteE  out  1  registered controls
ResultSrcE  out  2  registered control
Rs1E, Rs2E, RdE  out  reg_addr_width  registered indices, to hazard unit
PCPlus4E  out  word_width  registered
ALUResultE  out  word_width  ALU result
WriteDataE  out  word_width  forwarded B operand, before the immediate mux
PCTargetE  out  word_width  PCE + ImmExtE
PCSrcE  out  1  redirect fetch

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Register priority per rising edge: reset > FlushE > StallE > load D inputs.
- reset or FlushE:
  - Every ID/EX field goes to 0, control and data.
  - Consequently RegWriteE, MemWriteE, PCSrcE = 0 and ResultSrcE = 0.
  - Rs1E, Rs2E, RdE = 0. PCPlus4E = 0.
  - ALUResultE = 0 (0+0). PCTargetE = 0.
- FlushE together with StallE: the flush wins and a bubble is inserted.
- StallE alone: every field holds. Combinational outputs recompute from the held fields plus the current forwarding inputs.
- Latency:
  - D inputs appear on the registered E outputs 1 cycle later.
  - ALUResultE, WriteDataE, PCTargetE and PCSrcE are combinational from the E registers and the forwarding inputs. No extra latency.
- SrcA mux on ForwardAE: 00 = RD1E, 01 = ResultW, 10 = ALUResultM, 11 = RD1E (reserved).
- WriteDataE mux on ForwardBE: same encoding applied to RD2E.
- SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALU by ALUControlE:
  - 000: add.
  - 001: sub.
  - 010: and.
  - 011: or.
  - 101: slt, signed compare, result is 0 or 1 zero-extended.
  - Any other code: result 0, never X.
- ALU arithmetic is modulo 2^word_width; overflow is ignored.
- ZeroE = (ALUResultE == 0).
- PCSrcE = (BranchE & ZeroE) | JumpE.
- PCTargetE = PCE + ImmExtE, modulo 2^word_width.
- No X may propagate to any output after reset.
- jalr is not supported by this block.

Decomposition:
- riscv_pkg:
  - alu_op_t enum: ADD=000, SUB=001, AND=010, OR=011, SLT=101.
  - fwd_sel_t enum: REG=00, WB=01, MEM=10.
  - idex_t packed struct holding all ID/EX fields, so a bubble is a single assignment of '0.
- Sub-module alu: word_width parameter; inputs a, b, alu_op_t; outputs result and zero. It is reused by later stages.

Test Plan:
- Reset: hold reset 2 cycles with random D inputs -> all outputs 0 and PCSrcE = 0.
- Add with forwarding:
  - Stimulus: RD1D = 5, ALUControlD = 000, ALUSrcD = 1, ImmExtD = 7, ForwardAE = 00.
  - Required: ALUResultE = 12 one cycle later.
  - Then set ForwardAE = 10 with ALUResultM = 100 -> ALUResultE = 107.
- Sub and beq taken:
  - Stimulus: RD1D = RD2D = 0x1234, ALUControlD = 001, BranchD = 1, PCD = 0x40, ImmExtD = 0xFFFFFFF8.
  - Required: ZeroE = 1, PCSrcE = 1, PCTargetE = 0x38.
  - Then RD2D = 0x1235 -> PCSrcE = 0.
- Signed slt:
  - Stimulus: SrcA = 0xFFFFFFFF, SrcB = 1, ALUControlD = 101 -> ALUResultE = 1.
  - Swap the operands -> ALUResultE = 0.
- Stall then flush:
  - Load an add with RdD = 3 and RegWriteD = 1, then assert StallE for 2 cycles while the D inputs change.
  - Required: RdE stays 3 and RegWriteE stays 1.
  - Then assert FlushE and StallE together -> next cycle RegWriteE = 0 and RdE = 0.
- Jump and reserved codes:
  - JumpD = 1, BranchD = 0 -> PCSrcE = 1 regardless of ZeroE.
  - ALUControlD = 111 -> ALUResultE = 0.
  - ForwardBE = 11 -> WriteDataE = RD2E.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline.
//   alu_op_t  : 3-bit ALU operation codes produced by the ALU decoder
//   fwd_sel_t : hazard-unit forwarding selects
//   idex_t    : every ID/EX pipeline field, so a bubble is a single '0 assignment
//   fwd_mux   : operand forwarding mux shared by the SrcA and WriteData paths
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RegAddrW = 5;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        FwdReg = 2'b00,
        FwdWb  = 2'b01,
        FwdMem = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                reg_write;
        logic [1:0]          result_src;
        logic                mem_write;
        logic                jump;
        logic                branch;
        alu_op_t             alu_control;
        logic                alu_src;
        logic [XLEN-1:0]     rd1;
        logic [XLEN-1:0]     rd2;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     pc_plus4;
        logic [XLEN-1:0]     imm_ext;
        logic [RegAddrW-1:0] rs1;
        logic [RegAddrW-1:0] rs2;
        logic [RegAddrW-1:0] rd;
    } idex_t;

    // Select 2'b11 is reserved and falls back to the register value.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] reg_val,
                                                input logic [XLEN-1:0] wb_val,
                                                input logic [XLEN-1:0] mem_val);
        logic [XLEN-1:0] res;
        res = reg_val;
        case (sel)
            FwdWb:   res = wb_val;
            FwdMem:  res = mem_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu.sv
// Integer ALU for the RV32I pipeline.
//   a_i, b_i  : operands (word_width bits)
//   alu_op_i  : operation select (alu_op_t)
//   result_o  : result, modulo 2^word_width; unsupported codes give 0
//   zero_o    : high when result_o is zero
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned word_width = XLEN
) (
    input  logic [word_width-1:0] a_i,
    input  logic [word_width-1:0] b_i,
    input  alu_op_t               alu_op_i,
    output logic [word_width-1:0] result_o,
    output logic                  zero_o
);

    always_comb begin
        result_o = '0;
        case (alu_op_i)
            AluAdd:  result_o = a_i + b_i;
            AluSub:  result_o = a_i - b_i;
            AluAnd:  result_o = a_i & b_i;
            AluOr:   result_o = a_i | b_i;
            AluSlt:  result_o = {{(word_width-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// ID/EX pipeline register plus execute logic for the 5-stage RV32I pipeline.
//   clk, reset            : clock, synchronous active-high reset
//   StallE, FlushE        : hold / bubble the ID/EX register (flush wins)
//   *D inputs             : decode-stage controls, operands, PC values, register indices
//   ForwardAE, ForwardBE  : forwarding selects from the hazard unit
//   ALUResultM, ResultW   : forwarded values from MEM and WB
//   *E outputs            : registered controls/indices, ALU result, store data,
//                           branch target and fetch redirect (PCSrcE)
// Only jal/beq redirects are resolved here; jalr is not handled.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int unsigned word_width     = XLEN,
    parameter int unsigned reg_addr_width = RegAddrW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      RegWriteD,
    input  logic [1:0]                ResultSrcD,
    input  logic                      MemWriteD,
    input  logic                      JumpD,
    input  logic                      BranchD,
    input  logic [2:0]                ALUControlD,
    input  logic                      ALUSrcD,
    input  logic [word_width-1:0]     RD1D,
    input  logic [word_width-1:0]     RD2D,
    input  logic [word_width-1:0]     PCD,
    input  logic [word_width-1:0]     PCPlus4D,
    input  logic [word_width-1:0]     ImmExtD,
    input  logic [reg_addr_width-1:0] Rs1D,
    input  logic [reg_addr_width-1:0] Rs2D,
    input  logic [reg_addr_width-1:0] RdD,
    input  logic [1:0]                ForwardAE,
    input  logic [1:0]                ForwardBE,
    input  logic [word_width-1:0]     ALUResultM,
    input  logic [word_width-1:0]     ResultW,
    output logic                      RegWriteE,
    output logic                      MemWriteE,
    output logic [1:0]                ResultSrcE,
    output logic [reg_addr_width-1:0] Rs1E,
    output logic [reg_addr_width-1:0] Rs2E,
    output logic [reg_addr_width-1:0] RdE,
    output logic [word_width-1:0]     PCPlus4E,
    output logic [word_width-1:0]     ALUResultE,
    output logic [word_width-1:0]     WriteDataE,
    output logic [word_width-1:0]     PCTargetE,
    output logic                      PCSrcE
);

    idex_t idex_d, idex_q;

    always_comb begin
        idex_d             = '0;
        idex_d.reg_write   = RegWriteD;
        idex_d.result_src  = ResultSrcD;
        idex_d.mem_write   = MemWriteD;
        idex_d.jump        = JumpD;
        idex_d.branch      = BranchD;
        // Unsupported codes are carried as-is; the ALU maps them to 0.
        idex_d.alu_control = alu_op_t'(ALUControlD);
        idex_d.alu_src     = ALUSrcD;
        idex_d.rd1         = RD1D;
        idex_d.rd2         = RD2D;
        idex_d.pc          = PCD;
        idex_d.pc_plus4    = PCPlus4D;
        idex_d.imm_ext     = ImmExtD;
        idex_d.rs1         = Rs1D;
        idex_d.rs2         = Rs2D;
        idex_d.rd          = RdD;
    end

    // reset > flush > stall > load; a bubble clears data as well as control.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else if (!StallE) begin
            idex_q <= idex_d;
        end
    end

    logic [word_width-1:0] src_a, src_b;
    logic                  zero_e;

    assign src_a      = fwd_mux(ForwardAE, idex_q.rd1, ResultW, ALUResultM);
    assign WriteDataE = fwd_mux(ForwardBE, idex_q.rd2, ResultW, ALUResultM);
    assign src_b      = idex_q.alu_src ? idex_q.imm_ext : WriteDataE;

    alu #(
        .word_width(word_width)
    ) u_alu (
        .a_i      (src_a),
        .b_i      (src_b),
        .alu_op_i (idex_q.alu_control),
        .result_o (ALUResultE),
        .zero_o   (zero_e)
    );

    assign PCTargetE  = idex_q.pc + idex_q.imm_ext;
    assign PCSrcE     = (idex_q.branch & zero_e) | idex_q.jump;

    assign RegWriteE  = idex_q.reg_write;
    assign MemWriteE  = idex_q.mem_write;
    assign ResultSrcE = idex_q.result_src;
    assign Rs1E       = idex_q.rs1;
    assign Rs2E       = idex_q.rs2;
    assign RdE        = idex_q.rd;
    assign PCPlus4E   = idex_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset, StallE, FlushE;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD, ALUResultM, ResultW;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteE, MemWriteE, PCSrcE;
    logic [1:0]  ResultSrcE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [31:0] PCPlus4E, ALUResultE, WriteDataE, PCTargetE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk         (clk),
        .reset       (reset),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .RegWriteD   (RegWriteD),
        .ResultSrcD  (ResultSrcD),
        .MemWriteD   (MemWriteD),
        .JumpD       (JumpD),
        .BranchD     (BranchD),
        .ALUControlD (ALUControlD),
        .ALUSrcD     (ALUSrcD),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ImmExtD     (ImmExtD),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdD         (RdD),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ALUResultM  (ALUResultM),
        .ResultW     (ResultW),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .PCPlus4E    (PCPlus4E),
        .ALUResultE  (ALUResultE),
        .WriteDataE  (WriteDataE),
        .PCTargetE   (PCTargetE),
        .PCSrcE      (PCSrcE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0;
        ALUControlD = 0; ALUSrcD = 0; RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0;
        ImmExtD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
        ForwardAE = 0; ForwardBE = 0; ALUResultM = 0; ResultW = 0;
    endtask

    initial begin
        // Reset with random D inputs
        reset = 1; StallE = 0; FlushE = 0;
        RegWriteD = 1; MemWriteD = 1; JumpD = 1; BranchD = 1; ALUSrcD = $urandom_range(0, 1);
        ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
        RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom;
        ImmExtD = $urandom; Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
        ForwardAE = 0; ForwardBE = 0; ALUResultM = $urandom; ResultW = $urandom;
        tick();
        tick();
        chk("rst_regwrite", 32'(RegWriteE), 0);
        chk("rst_memwrite", 32'(MemWriteE), 0);
        chk("rst_resultsrc", 32'(ResultSrcE), 0);
        chk("rst_rs1", 32'(Rs1E), 0);
        chk("rst_rs2", 32'(Rs2E), 0);
        chk("rst_rd", 32'(RdE), 0);
        chk("rst_pcplus4", PCPlus4E, 0);
        chk("rst_aluresult", ALUResultE, 0);
        chk("rst_writedata", WriteDataE, 0);
        chk("rst_pctarget", PCTargetE, 0);
        chk("rst_pcsrc", 32'(PCSrcE), 0);

        // Add with immediate, then forwarding on A
        reset = 0;
        clear_d();
        RD1D = 5; ALUControlD = 3'b000; ALUSrcD = 1; ImmExtD = 7;
        RegWriteD = 1; MemWriteD = 1; ResultSrcD = 2'b10; RdD = 3; Rs1D = 1; Rs2D = 2;
        PCD = 32'h100; PCPlus4D = 32'h104;
        tick();
        chk("add_result", ALUResultE, 12);
        chk("add_regwrite", 32'(RegWriteE), 1);
        chk("add_memwrite", 32'(MemWriteE), 1);
        chk("add_resultsrc", 32'(ResultSrcE), 2);
        chk("add_rs1", 32'(Rs1E), 1);
        chk("add_rs2", 32'(Rs2E), 2);
        chk("add_rd", 32'(RdE), 3);
        chk("add_pcplus4", PCPlus4E, 32'h104);
        chk("add_pctarget", PCTargetE, 32'h107);
        chk("add_pcsrc", 32'(PCSrcE), 0);
        ForwardAE = 2'b10; ALUResultM = 100; #1;
        chk("fwdA_mem", ALUResultE, 107);
        ForwardAE = 2'b01; ResultW = 50; #1;
        chk("fwdA_wb", ALUResultE, 57);
        ForwardAE = 2'b11; #1;
        chk("fwdA_reserved", ALUResultE, 12);

        // Sub / beq taken, then not taken
        clear_d();
        RD1D = 32'h1234; RD2D = 32'h1234; ALUControlD = 3'b001; BranchD = 1;
        PCD = 32'h40; ImmExtD = 32'hFFFF_FFF8;
        tick();
        chk("beq_result", ALUResultE, 0);
        chk("beq_pcsrc", 32'(PCSrcE), 1);
        chk("beq_target", PCTargetE, 32'h38);
        chk("beq_writedata", WriteDataE, 32'h1234);
        RD2D = 32'h1235;
        tick();
        chk("bne_pcsrc", 32'(PCSrcE), 0);
        chk("bne_result", ALUResultE, 32'hFFFF_FFFF);
        ForwardBE = 2'b10; ALUResultM = 32'h1234; #1;
        chk("fwdB_mem_wd", WriteDataE, 32'h1234);
        chk("fwdB_mem_pcsrc", 32'(PCSrcE), 1);
        ForwardBE = 2'b01; ResultW = 32'h1000; #1;
        chk("fwdB_wb_wd", WriteDataE, 32'h1000);
        chk("fwdB_wb_result", ALUResultE, 32'h0234);
        chk("fwdB_wb_pcsrc", 32'(PCSrcE), 0);

        // Signed slt
        clear_d();
        RD1D = 32'hFFFF_FFFF; RD2D = 1; ALUControlD = 3'b101;
        tick();
        chk("slt_neg_lt_pos", ALUResultE, 1);
        RD1D = 1; RD2D = 32'hFFFF_FFFF;
        tick();
        chk("slt_pos_lt_neg", ALUResultE, 0);

        // AND / OR with immediate operand
        clear_d();
        RD1D = 32'hF0F0_00FF; ImmExtD = 32'h0FF0_0F0F; ALUSrcD = 1; ALUControlD = 3'b010;
        tick();
        chk("and_result", ALUResultE, 32'h00F0_000F);
        ALUControlD = 3'b011;
        tick();
        chk("or_result", ALUResultE, 32'hFFF0_0FFF);

        // Stall holds, flush+stall bubbles
        clear_d();
        RD1D = 1; ImmExtD = 2; ALUSrcD = 1; RdD = 3; RegWriteD = 1; PCPlus4D = 32'h20;
        tick();
        chk("pre_stall_rd", 32'(RdE), 3);
        StallE = 1; RdD = 9; RegWriteD = 0; RD1D = 100; ImmExtD = 50;
        tick();
        chk("stall1_rd", 32'(RdE), 3);
        chk("stall1_regwrite", 32'(RegWriteE), 1);
        chk("stall1_result", ALUResultE, 3);
        tick();
        chk("stall2_rd", 32'(RdE), 3);
        chk("stall2_regwrite", 32'(RegWriteE), 1);
        ForwardAE = 2'b10; ALUResultM = 10; #1;
        chk("stall_fwd_result", ALUResultE, 12);
        ForwardAE = 2'b00; FlushE = 1;
        tick();
        chk("flush_regwrite", 32'(RegWriteE), 0);
        chk("flush_rd", 32'(RdE), 0);
        chk("flush_result", ALUResultE, 0);
        chk("flush_pcplus4", PCPlus4E, 0);
        chk("flush_pcsrc", 32'(PCSrcE), 0);
        FlushE = 0; StallE = 0;

        // Jump regardless of zero; reserved ALU codes
        clear_d();
        JumpD = 1; RD1D = 5; ImmExtD = 1; ALUSrcD = 1; PCD = 32'h200;
        tick();
        chk("jump_result", ALUResultE, 6);
        chk("jump_pcsrc", 32'(PCSrcE), 1);
        chk("jump_target", PCTargetE, 32'h201);
        clear_d();
        RD1D = 5; RD2D = 3; ALUControlD = 3'b111;
        tick();
        chk("alu_111", ALUResultE, 0);
        ALUControlD = 3'b100;
        tick();
        chk("alu_100", ALUResultE, 0);
        ALUControlD = 3'b110;
        tick();
        chk("alu_110", ALUResultE, 0);

        // ForwardBE reserved code selects RD2E
        clear_d();
        RD2D = 32'hABCD; ALUResultM = 1; ResultW = 2; ForwardBE = 2'b11;
        tick();
        chk("fwdB_reserved", WriteDataE, 32'hABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
